// File: rtl/setup_pkg.sv
// rtl/setup_pkg.sv - shared types, key codes and BCD helper for the setup menu
package setup_pkg;

  typedef logic [5:0][3:0] bcdPac_t;

  localparam logic [3:0] KEY_CONFIRM = 4'hF;
  localparam logic [3:0] KEY_CANCEL  = 4'hE;
  localparam logic [3:0] BCD_BLANK   = 4'hA;

  typedef enum logic [1:0] {ITEM_STATUS, ITEM_TIME, ITEM_PIN} item_kind_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EDIT, ST_DONE} menu_state_t;

  typedef struct packed {
    item_kind_t kind;
    logic [2:0] slot;
  } item_dec_t;

  function automatic logic [7:0] bin2bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/setup_entry_buf.sv
// rtl/setup_entry_buf.sv - 4-digit BCD entry buffer with load, shift-in and clear-to-blank
module setup_entry_buf
  import setup_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [3:0]  digit,
  output logic [15:0] val
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       val <= {4{BCD_BLANK}};
    else if (clear) val <= {4{BCD_BLANK}};
    else if (load)  val <= load_val;
    else if (shift) val <= {val[11:0], digit};
  end

endmodule

// File: rtl/setup_menu_param.sv
// rtl/setup_menu_param.sv - parametrised setup menu editing a working copy of the lock config
// Optional idle auto-abort is compiled in with SETUP_TIMEOUT_EN.
module setup_menu_param
  import setup_pkg::*;
#(
  parameter int N_PINS        = 4,
  parameter int PIN_DIGITS    = 4,
  parameter int TIME_MIN      = 5,
  parameter int TIME_MAX      = 60,
  parameter int TIMEOUT_TICKS = 30,
  parameter int TIME_W        = $clog2(TIME_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         setup_on,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         tick,
  input  logic                         bip_en_old,
  input  logic [TIME_W-1:0]            bip_time_old,
  input  logic [TIME_W-1:0]            lock_time_old,
  input  logic [N_PINS-1:0]            pin_en_old,
  input  logic [N_PINS*PIN_DIGITS*4-1:0] pin_old,
  output logic                         bip_en_new,
  output logic [TIME_W-1:0]            bip_time_new,
  output logic [TIME_W-1:0]            lock_time_new,
  output logic [N_PINS-1:0]            pin_en_new,
  output logic [N_PINS*PIN_DIGITS*4-1:0] pin_new,
  output logic                         cfg_commit,
  output logic                         setup_end,
  output bcdPac_t                      bcd_out,
  output logic                         bcd_enable
);

  localparam int SLOT_W = PIN_DIGITS * 4;
  localparam int PIN_W  = N_PINS * SLOT_W;
  localparam logic [4:0] LAST = 5'(2 * N_PINS + 2);

  menu_state_t state, state_d;
  logic [4:0] idx, idx_d;
  logic w_bip_en, w_bip_en_d;
  logic [TIME_W-1:0] w_bip_time, w_bip_time_d, w_lock_time, w_lock_time_d;
  logic [N_PINS-1:0] w_pin_en, w_pin_en_d, slot_mask;
  logic [PIN_W-1:0] w_pin, w_pin_d;
  logic buf_clear, buf_load, buf_shift;
  logic [15:0] buf_load_val, buf_val;
  logic abort, commit, timeout;
  bcdPac_t bcd_prev;
  item_dec_t dec;

  function automatic item_dec_t decode_item(input logic [4:0] i);
    item_dec_t d;
    d.kind = ITEM_STATUS;
    d.slot = '0;
    case (i)
      5'd1:       d.kind = ITEM_STATUS;
      5'd2, 5'd3: d.kind = ITEM_TIME;
      5'd4:       d.kind = ITEM_PIN;
      default: begin
        d.kind = i[0] ? ITEM_STATUS : ITEM_PIN;
        d.slot = 3'((i - 5'd3) >> 1);
      end
    endcase
    return d;
  endfunction

  function automatic logic [15:0] field_of(input logic [4:0] i, input logic ben,
                                           input logic [TIME_W-1:0] bt, input logic [TIME_W-1:0] lt,
                                           input logic [N_PINS-1:0] pen, input logic [PIN_W-1:0] pins);
    item_dec_t d;
    logic [15:0] f;
    d = decode_item(i);
    f = {4{BCD_BLANK}};
    case (d.kind)
      ITEM_STATUS: f[3:0] = {3'b000, (i == 5'd1) ? ben : |(pen & (N_PINS'(1) << d.slot))};
      ITEM_TIME:   f[7:0] = bin2bcd2(32'((i == 5'd2) ? bt : lt));
      ITEM_PIN:    f[SLOT_W-1:0] = pins[32'(d.slot)*SLOT_W +: SLOT_W];
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [TIME_W-1:0] clamp_time(input logic [7:0] f);
    int v;
    v = int'(f[7:4]) * 10 + int'(f[3:0]);
    if (v < TIME_MIN)      v = TIME_MIN;
    else if (v > TIME_MAX) v = TIME_MAX;
    return TIME_W'(v);
  endfunction

  assign dec       = decode_item(idx);
  assign slot_mask = N_PINS'(1) << dec.slot;
  assign setup_end = (state == ST_DONE);

`ifdef SETUP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 idle_cnt <= '0;
    else if (state == ST_LOAD || key_valid)   idle_cnt <= '0;
    else if (state == ST_EDIT && tick && idle_cnt != CNT_W'(TIMEOUT_TICKS))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idle_cnt == CNT_W'(TIMEOUT_TICKS));
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_tick;
  assign unused_tick = tick;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Abort is checked before the key so a falling setup_on drops a coincident key.
  always_comb begin
    state_d = state;
    abort   = 1'b0;
    commit  = 1'b0;
    case (state)
      ST_IDLE: if (setup_on) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_EDIT;
      ST_EDIT: begin
        abort = !setup_on || timeout || (key_valid && key_code == KEY_CANCEL);
        if (abort) state_d = ST_DONE;
        else if (key_valid && key_code == KEY_CONFIRM && idx == LAST) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!setup_on) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bip_en_d    = w_bip_en;
    w_bip_time_d  = w_bip_time;
    w_lock_time_d = w_lock_time;
    w_pin_en_d    = w_pin_en;
    w_pin_d       = w_pin;
    idx_d         = idx;
    buf_clear     = (state == ST_EDIT) && (state_d == ST_DONE);
    buf_load      = 1'b0;
    buf_shift     = 1'b0;
    buf_load_val  = {{3{BCD_BLANK}}, key_code};
    if (state == ST_LOAD) begin
      w_bip_en_d    = bip_en_old;
      w_bip_time_d  = bip_time_old;
      w_lock_time_d = lock_time_old;
      w_pin_en_d    = pin_en_old;
      w_pin_d       = pin_old;
      idx_d         = 5'd1;
      buf_load      = 1'b1;
      buf_load_val  = field_of(5'd1, bip_en_old, bip_time_old, lock_time_old, pin_en_old, pin_old);
    end else if (state == ST_EDIT && !abort && key_valid) begin
      if (key_code <= 4'd9) begin
        if (dec.kind != ITEM_STATUS) buf_shift = 1'b1;
        else if (key_code <= 4'd1) begin
          buf_load = 1'b1;
          if (idx == 5'd1)      w_bip_en_d = key_code[0];
          else if (key_code[0]) w_pin_en_d = w_pin_en | slot_mask;
          else                  w_pin_en_d = w_pin_en & ~slot_mask;
        end
      end else if (key_code == KEY_CONFIRM) begin
        case (dec.kind)
          ITEM_TIME: begin
            if (idx == 5'd2) w_bip_time_d  = clamp_time(buf_val[7:0]);
            else             w_lock_time_d = clamp_time(buf_val[7:0]);
          end
          ITEM_PIN: begin
            w_pin_d[32'(dec.slot)*SLOT_W +: SLOT_W] = buf_val[SLOT_W-1:0];
            w_pin_en_d[0] = 1'b1;
          end
          default: ;
        endcase
        if (idx != LAST) begin
          idx_d        = idx + 5'd1;
          buf_load     = 1'b1;
          buf_load_val = field_of(idx + 5'd1, w_bip_en, w_bip_time, w_lock_time, w_pin_en, w_pin);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_bip_en      <= 1'b0;
      w_bip_time    <= '0;
      w_lock_time   <= '0;
      w_pin_en      <= '0;
      w_pin         <= '0;
      idx           <= '0;
      bip_en_new    <= 1'b0;
      bip_time_new  <= '0;
      lock_time_new <= '0;
      pin_en_new    <= '0;
      pin_new       <= '0;
      cfg_commit    <= 1'b0;
      bcd_prev      <= {6{BCD_BLANK}};
    end else begin
      w_bip_en    <= w_bip_en_d;
      w_bip_time  <= w_bip_time_d;
      w_lock_time <= w_lock_time_d;
      w_pin_en    <= w_pin_en_d;
      w_pin       <= w_pin_d;
      idx         <= idx_d;
      cfg_commit  <= commit;
      bcd_prev    <= bcd_out;
      if (commit) begin
        bip_en_new    <= w_bip_en_d;
        bip_time_new  <= w_bip_time_d;
        lock_time_new <= w_lock_time_d;
        pin_en_new    <= w_pin_en_d;
        pin_new       <= w_pin_d;
      end
    end
  end

  setup_entry_buf u_entry (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear),
    .load     (buf_load),
    .load_val (buf_load_val),
    .shift    (buf_shift),
    .digit    (key_code),
    .val      (buf_val)
  );

  // Only the digits that belong to the current item are shown; the rest stay blank.
  always_comb begin
    bcd_out = {6{BCD_BLANK}};
    if (state == ST_EDIT) begin
      {bcd_out[5], bcd_out[4]} = bin2bcd2(32'(idx));
      case (dec.kind)
        ITEM_STATUS: bcd_out[0] = buf_val[3:0];
        ITEM_TIME: begin
          bcd_out[1] = buf_val[7:4];
          bcd_out[0] = buf_val[3:0];
        end
        ITEM_PIN: for (int i = 0; i < PIN_DIGITS; i++) bcd_out[i] = buf_val[4*i +: 4];
        default: ;
      endcase
    end
  end

  assign bcd_enable = (bcd_out != bcd_prev);

endmodule

// File: tb/tb_setup_menu_param.sv
// tb/tb_setup_menu_param.sv - scoreboard bench for setup_menu_param (timeout cases follow SETUP_TIMEOUT_EN)
module tb_setup_menu_param;
  import setup_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        setup_on = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        tick = 1'b0;
  logic        bip_en_old = 1'b1;
  logic [5:0]  bip_time_old = 6'd10;
  logic [5:0]  lock_time_old = 6'd20;
  logic [3:0]  pin_en_old = 4'b0001;
  logic [63:0] pin_old = 64'h3333_2222_1111_1234;
  logic        bip_en_new;
  logic [5:0]  bip_time_new, lock_time_new;
  logic [3:0]  pin_en_new;
  logic [63:0] pin_new;
  logic        cfg_commit, setup_end, bcd_enable;
  bcdPac_t     bcd_out;

  setup_menu_param #(
    .N_PINS(4), .PIN_DIGITS(4), .TIME_MIN(5), .TIME_MAX(60), .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .setup_on(setup_on), .key_valid(key_valid), .key_code(key_code),
    .tick(tick), .bip_en_old(bip_en_old), .bip_time_old(bip_time_old),
    .lock_time_old(lock_time_old), .pin_en_old(pin_en_old), .pin_old(pin_old),
    .bip_en_new(bip_en_new), .bip_time_new(bip_time_new), .lock_time_new(lock_time_new),
    .pin_en_new(pin_en_new), .pin_new(pin_new), .cfg_commit(cfg_commit),
    .setup_end(setup_end), .bcd_out(bcd_out), .bcd_enable(bcd_enable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_bcd[$];
  logic [80:0] exp_cfg[$];
  logic [80:0] dut_cfg;
  assign dut_cfg = {bip_en_new, bip_time_new, lock_time_new, pin_en_new, pin_new};

  // Displays reached by plain F presses from the stored config, items 2..10.
  logic [23:0] walk [0:8] = '{24'h02AA10, 24'h03AA20, 24'h041234, 24'h05AAA0, 24'h061111,
                              24'h07AAA0, 24'h082222, 24'h09AAA0, 24'h103333};

  localparam logic [80:0] CFG_OLD = {1'b1, 6'd10, 6'd20, 4'b0001, 64'h3333_2222_1111_1234};
  localparam logic [80:0] CFG_T60 = {1'b1, 6'd60, 6'd20, 4'b0001, 64'h3333_2222_1111_1234};
  localparam logic [80:0] CFG_T05 = {1'b1, 6'd5,  6'd20, 4'b0001, 64'h3333_2222_1111_1234};
  localparam logic [80:0] CFG_P1  = {1'b1, 6'd10, 6'd20, 4'b0011, 64'h3333_2222_8765_1234};

  task automatic check(input string name, input logic [80:0] got, input logic [80:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bcd_enable) begin
          if (exp_bcd.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bcd_unexpected: got %h, required no pulse", bcd_out);
          end else check("bcd_out", 81'(bcd_out), 81'(exp_bcd.pop_front()));
        end
        if (cfg_commit) begin
          if (exp_cfg.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL commit_unexpected: got %h, required no pulse", dut_cfg);
          end else check("cfg_new", dut_cfg, exp_cfg.pop_front());
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cycles(1);
    key_valid = 1'b0;
    cycles(1);
  endtask

  task automatic key_exp(input logic [3:0] c, input logic [23:0] v);
    exp_bcd.push_back(v);
    press(c);
  endtask

  task automatic walk_f(input int from_idx, input int to_idx);
    for (int i = from_idx; i <= to_idx; i++) key_exp(KEY_CONFIRM, walk[i-2]);
  endtask

  task automatic commit_f(input logic [80:0] c);
    exp_cfg.push_back(c);
    key_exp(KEY_CONFIRM, 24'hAAAAAA);
  endtask

  task automatic start();
    exp_bcd.push_back(24'h01AAA1);
    setup_on = 1'b1;
    cycles(3);
  endtask

  task automatic leave(input string name);
    check({name, "_end_high"}, 81'(setup_end), 81'(1));
    setup_on = 1'b0;
    cycles(2);
    check({name, "_end_low"}, 81'(setup_end), 81'(0));
  endtask

  task automatic tick_pulse(input int n);
    repeat (n) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(1);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    #12;
    check("rst_bcd", 81'(bcd_out), 81'(24'hAAAAAA));
    check("rst_flags", 81'({setup_end, cfg_commit, bcd_enable}), 81'(0));
    check("rst_cfg", dut_cfg, 81'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(1);

    // Walk every item untouched; commit must reproduce the stored config.
    start();
    walk_f(2, 10);
    commit_f(CFG_OLD);
    leave("walk");

    // Beep time clamps high then low.
    start();
    key_exp(KEY_CONFIRM, 24'h02AA10);
    key_exp(4'd7, 24'h02AA07);
    key_exp(4'd5, 24'h02AA75);
    walk_f(3, 10);
    commit_f(CFG_T60);
    leave("clamp_hi");

    start();
    key_exp(KEY_CONFIRM, 24'h02AA10);
    key_exp(4'd0, 24'h02AA00);
    key_exp(4'd3, 24'h02AA03);
    walk_f(3, 10);
    commit_f(CFG_T05);
    leave("clamp_lo");

    // Enable PIN slot 1 and enter five digits; the oldest drops.
    start();
    walk_f(2, 5);
    key_exp(4'd1, 24'h05AAA1);
    walk_f(6, 6);
    key_exp(4'd9, 24'h061119);
    key_exp(4'd8, 24'h061198);
    key_exp(4'd7, 24'h061987);
    key_exp(4'd6, 24'h069876);
    key_exp(4'd5, 24'h068765);
    walk_f(7, 10);
    commit_f(CFG_P1);
    leave("pin1");

    // Cancel after edits: no commit, committed config untouched.
    start();
    walk_f(2, 2);
    key_exp(4'd9, 24'h02AA09);
    walk_f(3, 5);
    key_exp(4'd1, 24'h05AAA1);
    walk_f(6, 7);
    key_exp(KEY_CANCEL, 24'hAAAAAA);
    check("cancel_cfg", dut_cfg, CFG_P1);
    leave("cancel");

    // setup_on falls together with a key: abort wins, key dropped.
    start();
    exp_bcd.push_back(24'hAAAAAA);
    key_valid = 1'b1;
    key_code  = 4'd0;
    setup_on  = 1'b0;
    cycles(1);
    key_valid = 1'b0;
    cycles(2);
    check("drop_end_low", 81'(setup_end), 81'(0));
    check("drop_cfg", dut_cfg, CFG_P1);

    // Asynchronous reset mid-menu at item 3.
    start();
    walk_f(2, 3);
    #3;
    rst = 1'b0;
    setup_on = 1'b0;
    #1;
    check("mid_rst_bcd", 81'(bcd_out), 81'(24'hAAAAAA));
    check("mid_rst_flags", 81'({setup_end, cfg_commit, bcd_enable}), 81'(0));
    check("mid_rst_cfg", dut_cfg, 81'(0));
    cycles(1);
    rst = 1'b1;
    cycles(2);
    press(KEY_CONFIRM);
    press(4'd1);
    check("post_rst_bcd", 81'(bcd_out), 81'(24'hAAAAAA));
    check("post_rst_end", 81'(setup_end), 81'(0));

`ifdef SETUP_TIMEOUT_EN
    start();
    exp_bcd.push_back(24'hAAAAAA);
    tick_pulse(3);
    cycles(1);
    check("timeout_abort", 81'(setup_end), 81'(1));
    setup_on = 1'b0;
    cycles(2);
    start();
    tick_pulse(2);
    press(4'hA);
    tick_pulse(2);
    cycles(2);
    check("timeout_restart", 81'(setup_end), 81'(0));
    exp_bcd.push_back(24'hAAAAAA);
    tick_pulse(1);
    cycles(2);
    check("timeout_after_restart", 81'(setup_end), 81'(1));
    setup_on = 1'b0;
    cycles(2);
`else
    start();
    tick_pulse(100);
    check("no_timeout", 81'(setup_end), 81'(0));
    key_exp(KEY_CANCEL, 24'hAAAAAA);
    leave("no_timeout");
`endif

    cycles(3);
    check("bcd_queue_drained", 81'(exp_bcd.size()), 81'(0));
    check("cfg_queue_drained", 81'(exp_cfg.size()), 81'(0));
    check("final_cfg", dut_cfg, 81'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
